// File: rtl/ad_frame_builder.sv
// ad_frame_builder: samples the AD bus once per symbol period while sync is
// active, buffers samples in a FIFO and emits framed bytes over valid/ready:
// 0x55 0x55 0xD5 <seq> <payload x PAYLOAD_LEN> <checksum>.
// Optional feature macro: AD_FRAME_CRC8_EN
//   defined   -> checksum is CRC-8 (poly 0x07, init 0x00, MSB first)
//   undefined -> checksum is the XOR of the payload bytes
module ad_frame_builder #(
  parameter int unsigned SYMBOL_CYCLES = 720,
  parameter int unsigned SAMPLE_OFFSET = 360,
  parameter int unsigned PAYLOAD_LEN   = 4,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       sender_sync_in,
  input  logic [7:0] sender_ad,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic [7:0] overflow_cnt
);

  localparam int unsigned CntW  = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FillW = PtrW + 1;
  localparam int unsigned IdxW  = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;

  localparam logic [CntW-1:0]  SymLast   = CntW'(SYMBOL_CYCLES - 1);
  localparam logic [CntW-1:0]  SampleOff = CntW'(SAMPLE_OFFSET);
  localparam logic [FillW-1:0] FifoFull  = FillW'(FIFO_DEPTH);
  localparam logic [FillW-1:0] PayLen    = FillW'(PAYLOAD_LEN);
  localparam logic [IdxW-1:0]  PayLast   = IdxW'(PAYLOAD_LEN - 1);

  typedef enum logic [2:0] {
    StIdle, StPre0, StPre1, StSfd, StSeq, StPayload, StCheck
  } state_e;

  // Checksum step over one payload byte.
  function automatic logic [7:0] chk_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
`ifdef AD_FRAME_CRC8_EN
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
`endif
    return r;
  endfunction

  logic             sync_meta_q, sync_s_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
  logic [FillW-1:0] fill_q, fill_d;
  logic [7:0]       ovf_q, ovf_d;
  logic             hs, pop, push_req, push, drop, full, flush;
  logic [7:0]       head, next_head;

  state_e           state_q, state_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       chk_q, chk_d, chk_upd;
  logic [IdxW-1:0]  idx_q, idx_d;

  // Two-flop synchronizer for the asynchronous capture enable.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sync_meta_q <= 1'b0;
      sync_s_q    <= 1'b0;
    end else begin
      sync_meta_q <= sender_sync_in;
      sync_s_q    <= sync_meta_q;
    end
  end

  // Symbol counter, capture decision and FIFO bookkeeping.
  always_comb begin
    cnt_d = '0;
    if (sync_s_q) cnt_d = (cnt_q == SymLast) ? '0 : cnt_q + 1'b1;

    hs         = out_valid_q && out_ready;
    pop        = hs && (state_q == StPayload);
    full       = (fill_q == FifoFull);
    push_req   = sync_s_q && (cnt_q == SampleOff);
    push       = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    // Partial leftovers are discarded once the FSM is idle and sync is gone.
    flush      = (state_q == StIdle) && !sync_s_q && (fill_q < PayLen);
    rd_ptr_nxt = rd_ptr_q + 1'b1;
    head       = mem_q[rd_ptr_q];
    next_head  = mem_q[rd_ptr_nxt];

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      fill_d   = '0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_nxt;
      if (push && !pop) fill_d = fill_q + 1'b1;
      else if (pop && !push) fill_d = fill_q - 1'b1;
    end

    ovf_d = (drop && (ovf_q != 8'hFF)) ? ovf_q + 1'b1 : ovf_q;
  end

  // Counter, FIFO pointers and overflow counter state.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
    end
  end

  // Sample storage; contents are only meaningful behind the fill count.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= sender_ad;
  end

  // Frame FSM next state; outputs are computed one step ahead so they leave flops.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    seq_d       = seq_q;
    chk_d       = chk_q;
    idx_d       = idx_q;
    chk_upd     = chk_step(chk_q, out_data_q);

    unique case (state_q)
      StIdle: begin
        if (fill_q >= PayLen) begin
          state_d     = StPre0;
          out_valid_d = 1'b1;
          out_data_d  = 8'h55;
          out_last_d  = 1'b0;
        end
      end
      StPre0: begin
        if (hs) begin
          state_d    = StPre1;
          out_data_d = 8'h55;
        end
      end
      StPre1: begin
        if (hs) begin
          state_d    = StSfd;
          out_data_d = 8'hD5;
        end
      end
      StSfd: begin
        chk_d = '0;
        if (hs) begin
          state_d    = StSeq;
          out_data_d = seq_q;
        end
      end
      StSeq: begin
        if (hs) begin
          state_d    = StPayload;
          out_data_d = head;
          idx_d      = '0;
        end
      end
      StPayload: begin
        if (hs) begin
          chk_d = chk_upd;
          if (idx_q == PayLast) begin
            state_d    = StCheck;
            out_data_d = chk_upd;
            out_last_d = 1'b1;
          end else begin
            idx_d      = idx_q + 1'b1;
            out_data_d = next_head;
          end
        end
      end
      StCheck: begin
        if (hs) begin
          seq_d      = seq_q + 1'b1;
          out_last_d = 1'b0;
          if (fill_q >= PayLen) begin
            state_d    = StPre0;
            out_data_d = 8'h55;
          end else begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
          end
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = 8'h00;
      end
    endcase
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= StIdle;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      seq_q       <= 8'h00;
      chk_q       <= 8'h00;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      seq_q       <= seq_d;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign busy         = (state_q != StIdle);
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_ad_frame_builder.sv
// Scoreboard bench for ad_frame_builder: stimulus pushes expected frame bytes,
// a monitor pops and compares on every output handshake.
module tb_ad_frame_builder;

  localparam int unsigned SymCycles = 10;
  localparam int unsigned SampleOff = 4;
  localparam int unsigned PayLen    = 4;
  localparam int unsigned FifoDepth = 16;

  logic       clock = 1'b0;
  logic       resetN;
  logic       sender_sync_in;
  logic [7:0] sender_ad;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic [7:0] overflow_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];     // {last, data}
  logic [7:0] exp_seq;
  logic [7:0] stim_q[$];
  bit         rand_ready;
  logic       ready_val;

  ad_frame_builder #(
    .SYMBOL_CYCLES(SymCycles),
    .SAMPLE_OFFSET(SampleOff),
    .PAYLOAD_LEN  (PayLen),
    .FIFO_DEPTH   (FifoDepth)
  ) dut (
    .clock         (clock),
    .resetN        (resetN),
    .sender_sync_in(sender_sync_in),
    .sender_ad     (sender_ad),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .overflow_cnt  (overflow_cnt)
  );

  always #5 clock = ~clock;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h", name, act, req);
    end
  endtask

  function automatic logic [7:0] model_chk(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
`ifdef AD_FRAME_CRC8_EN
    for (int i = 0; i < 8; i++) begin
      if (r[7]) r = {r[6:0], 1'b0} ^ 8'h07;
      else      r = {r[6:0], 1'b0};
    end
`endif
    return r;
  endfunction

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] p[4];
    logic [7:0] c;
    p = '{b0, b1, b2, b3};
    c = 8'h00;
    exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    exp_q.push_back({1'b0, exp_seq});
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, p[i]});
      c = model_chk(c, p[i]);
    end
    exp_q.push_back({1'b1, c});
    exp_seq++;
  endtask

  // Raise sync, hold each queued AD value for one symbol period, then drop sync.
  task automatic run_samples();
    @(negedge clock);
    sender_ad      = stim_q[0];
    sender_sync_in = 1'b1;
    for (int i = 1; i < stim_q.size(); i++) begin
      repeat (SymCycles) @(posedge clock);
      @(negedge clock);
      sender_ad = stim_q[i];
    end
    repeat (SymCycles) @(posedge clock);
    @(negedge clock);
    sender_sync_in = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge clock);
      #2;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes pending, busy=%0b; expected 0 pending, busy=0",
               name, exp_q.size(), busy);
    end
    repeat (5) @(negedge clock);
  endtask

  // Output ready: fixed level or a random 50% pattern, changed just after each edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Monitor: compare every transferred byte and check stability during stalls.
  initial begin : monitor
    logic       stall;
    logic [7:0] sd;
    logic       sl;
    logic [8:0] e;
    stall = 1'b0;
    sd    = 8'h00;
    sl    = 1'b0;
    forever begin
      @(negedge clock);
      if (!resetN) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check8("stall_valid", {7'b0, out_valid}, 8'h01);
          check8("stall_data", out_data, sd);
          check8("stall_last", {7'b0, out_last}, {7'b0, sl});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %02h last=%0b, expected no transfer",
                     out_data, out_last);
          end else begin
            e = exp_q.pop_front();
            check8("frame_data", out_data, e[7:0]);
            check8("frame_last", {7'b0, out_last}, {7'b0, e[8]});
          end
        end
        stall = out_valid && !out_ready;
        sd    = out_data;
        sl    = out_last;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         vcnt;
    logic [8:0] basic[9];
    logic [7:0] v;
    resetN         = 1'b0;
    sender_sync_in = 1'b0;
    sender_ad      = 8'h00;
    ready_val      = 1'b1;
    rand_ready     = 1'b0;
    exp_seq        = 8'h00;

    // Reset values, then a long idle stretch with sync low.
    repeat (10) @(negedge clock);
    check8("rst_data", out_data, 8'h00);
    check8("rst_valid", {7'b0, out_valid}, 8'h00);
    check8("rst_last", {7'b0, out_last}, 8'h00);
    check8("rst_busy", {7'b0, busy}, 8'h00);
    check8("rst_ovf", overflow_cnt, 8'h00);
    @(posedge clock);
    #2 resetN = 1'b1;
    vcnt = 0;
    repeat (5000) begin
      @(negedge clock);
      if (out_valid) vcnt++;
    end
    check8("idle_valid_cycles", 8'(vcnt), 8'h00);

    // Basic frame with hand-computed bytes.
`ifndef AD_FRAME_CRC8_EN
    basic = '{9'h055, 9'h055, 9'h0D5, 9'h000, 9'h020, 9'h021, 9'h022, 9'h025, 9'h106};
    for (int i = 0; i < 9; i++) exp_q.push_back(basic[i]);
    exp_seq++;
`else
    basic = '{default: 9'h000};
    push_frame(8'h20, 8'h21, 8'h22, 8'h25);
`endif
    stim_q = '{8'h20, 8'h21, 8'h22, 8'h25};
    run_samples();
    wait_drain("basic");

    // Same payload under random backpressure.
    push_frame(8'h20, 8'h21, 8'h22, 8'h25);
    rand_ready = 1'b1;
    run_samples();
    wait_drain("backpressure");
    rand_ready = 1'b0;

    // Overflow: 20 samples with the output blocked, FIFO keeps the first 16.
    ready_val = 1'b0;
    repeat (3) @(negedge clock);
    stim_q.delete();
    for (int i = 0; i < 20; i++) stim_q.push_back(8'(8'h40 + i));
    for (int f = 0; f < 4; f++) begin
      v = 8'(8'h40 + 4 * f);
      push_frame(v, v + 8'd1, v + 8'd2, v + 8'd3);
    end
    run_samples();
    repeat (5) @(negedge clock);
    check8("ovf_cnt", overflow_cnt, 8'd4);
    check8("ovf_stall_valid", {7'b0, out_valid}, 8'h01);
    check8("ovf_stall_data", out_data, 8'h55);
    ready_val = 1'b1;
    wait_drain("overflow");
    check8("ovf_cnt_hold", overflow_cnt, 8'd4);

    // Sync drop after 6 samples: one frame, the two leftovers are flushed.
    stim_q = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    push_frame(8'h60, 8'h61, 8'h62, 8'h63);
    run_samples();
    wait_drain("sync_drop");
    check8("sync_drop_busy", {7'b0, busy}, 8'h00);

    // Reset mid-frame: everything clears and nothing resumes.
    push_frame(8'h70, 8'h71, 8'h72, 8'h73);
    ready_val = 1'b0;
    stim_q    = '{8'h70, 8'h71, 8'h72, 8'h73};
    run_samples();
    repeat (3) @(negedge clock);
    ready_val = 1'b1;
    repeat (3) @(negedge clock);
    ready_val = 1'b0;
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 resetN = 1'b0;
    exp_q.delete();
    exp_seq = 8'h00;
    @(negedge clock);
    check8("midrst_valid", {7'b0, out_valid}, 8'h00);
    check8("midrst_busy", {7'b0, busy}, 8'h00);
    check8("midrst_ovf", overflow_cnt, 8'h00);
    check8("midrst_data", out_data, 8'h00);
    check8("midrst_last", {7'b0, out_last}, 8'h00);
    repeat (3) @(negedge clock);
    ready_val = 1'b1;
    @(posedge clock);
    #2 resetN = 1'b1;
    vcnt = 0;
    repeat (50) begin
      @(negedge clock);
      if (out_valid) vcnt++;
    end
    check8("midrst_no_resume", 8'(vcnt), 8'h00);

    // 257 frames: the sequence byte wraps from 0xFF back to 0x00.
    stim_q.delete();
    for (int f = 0; f < 257; f++) begin
      v = 8'(4 * f);
      for (int k = 0; k < 4; k++) stim_q.push_back(v + 8'(k));
      push_frame(v, v + 8'd1, v + 8'd2, v + 8'd3);
    end
    run_samples();
    wait_drain("seq_wrap");
    check8("final_ovf", overflow_cnt, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
